// File: rtl/trace_event_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_event_sched_if
// Brief    : Trace record stream (valid/ready) from the scheduler to the sink.
// Revision : 1.0
// ============================================================================
interface trace_event_sched_if #(
    parameter int TS_W = 32
);
    logic            out_valid;
    logic            out_ready;
    logic            out_src;
    logic            out_ovf;
    logic [1:0]      out_type;
    logic [31:0]     out_pc;
    logic [31:0]     out_data;
    logic [TS_W-1:0] out_ts;

    modport master (
        output out_valid, out_src, out_ovf, out_type, out_pc, out_data, out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_src, out_ovf, out_type, out_pc, out_data, out_ts,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/trace_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : trace_event_sched
// Brief    : PC-windowed trace capture, per-source timestamped FIFOs with drop
//            accounting, round-robin merge onto one registered record stream.
// Revision : 1.0
// ============================================================================
module trace_event_sched #(
    parameter int DEPTH  = 4,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 cfg_enable,
    input  wire                 cfg_use_trigger,
    input  wire  [31:0]         cfg_start_pc,
    input  wire  [31:0]         cfg_stop_pc,
    input  wire                 if_evt_valid,
    input  wire  [1:0]          if_evt_type,
    input  wire  [31:0]         if_evt_pc,
    input  wire  [31:0]         if_evt_data,
    input  wire                 ex_evt_valid,
    input  wire  [1:0]          ex_evt_type,
    input  wire  [31:0]         ex_evt_pc,
    trace_event_sched_if.master rec,
    output logic                tracing,
    output logic [DROP_W-1:0]   drop_count
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    typedef struct packed {
        logic            ovf;
        logic [1:0]      etype;
        logic [31:0]     pc;
        logic [31:0]     data;
        logic [TS_W-1:0] ts;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_TRACING = 2'd2,
        S_STOPPED = 2'd3
    } state_t;

    state_t            r_state;
    logic [TS_W-1:0]   r_ts;
    logic [DROP_W-1:0] r_drop_count;
    logic              r_out_valid;
    logic              r_out_src;
    rec_t              r_out;
    logic              r_rr;

    logic              w_start_hit;
    logic              w_stop_hit;
    logic              w_gate;
    logic [1:0]        w_src_vld;
    rec_t              w_src_rec [2];
    rec_t              w_head    [2];
    logic [1:0]        w_empty;
    logic [1:0]        w_drop;
    logic [1:0]        w_pop;
    logic              w_load;
    logic              w_any;
    logic              w_sel;
    logic [DROP_W:0]   w_drop_sum;

    assign w_start_hit = (r_state == S_ARMED) && ex_evt_valid && (ex_evt_pc == cfg_start_pc);
    assign w_stop_hit  = cfg_use_trigger && ex_evt_valid && (ex_evt_pc == cfg_stop_pc);
    assign w_gate      = (r_state == S_TRACING) || w_start_hit;
    assign tracing     = (r_state == S_TRACING);

    always_ff @(posedge clk) begin
        if (!rst_n || !cfg_enable) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:    r_state <= cfg_use_trigger ? S_ARMED : S_TRACING;
                S_ARMED:   if (w_start_hit) r_state <= S_TRACING;
                S_TRACING: if (w_stop_hit)  r_state <= S_STOPPED;
                S_STOPPED: r_state <= S_STOPPED;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_ts <= '0;
        else        r_ts <= r_ts + TS_W'(1);
    end

    always_comb begin
        w_src_vld    = {ex_evt_valid, if_evt_valid} & {2{w_gate}};
        w_src_rec[0] = '{ovf: 1'b0, etype: if_evt_type, pc: if_evt_pc, data: if_evt_data, ts: r_ts};
        w_src_rec[1] = '{ovf: 1'b0, etype: ex_evt_type, pc: ex_evt_pc, data: 32'd0, ts: r_ts};
    end

    for (genvar s = 0; s < 2; s++) begin : g_src
        rec_t              r_mem [DEPTH];
        logic [AW-1:0]     r_wr;
        logic [AW-1:0]     r_rd;
        logic [AW:0]       r_cnt;
        logic [DROP_W-1:0] r_pend;
        logic              w_full;
        logic              w_mark;
        logic              w_push;
        rec_t              w_rec;

        // Fullness is sampled before this cycle's pop, so a pop never frees room for a same-cycle push.
        assign w_full     = (r_cnt == c_full);
        assign w_mark     = (r_pend != '0) && !w_full;
        assign w_push     = !w_full && (w_mark || w_src_vld[s]);
        assign w_drop[s]  = w_src_vld[s] && (w_full || w_mark);
        assign w_rec      = w_mark ? '{ovf: 1'b1, etype: 2'd0, pc: 32'd0, data: 32'(r_pend), ts: r_ts}
                                   : w_src_rec[s];
        assign w_empty[s] = (r_cnt == '0);
        assign w_head[s]  = r_mem[r_rd];

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr] <= w_rec;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wr   <= '0;
                r_rd   <= '0;
                r_cnt  <= '0;
                r_pend <= '0;
            end else begin
                if (w_push)   r_wr <= r_wr + AW'(1);
                if (w_pop[s]) r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop[s]};
                if (w_mark)
                    r_pend <= DROP_W'(w_src_vld[s]);
                else if (w_src_vld[s] && w_full && (r_pend != '1))
                    r_pend <= r_pend + DROP_W'(1);
            end
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + (DROP_W+1)'(w_drop[0]) + (DROP_W+1)'(w_drop[1]);
    assign drop_count = r_drop_count;

    always_ff @(posedge clk) begin
        if (!rst_n)                 r_drop_count <= '0;
        else if (w_drop_sum[DROP_W]) r_drop_count <= '1;
        else                         r_drop_count <= w_drop_sum[DROP_W-1:0];
    end

    // r_rr names the source preferred on the next contested grant.
    assign w_load = !r_out_valid || rec.out_ready;
    assign w_any  = !(&w_empty);
    assign w_sel  = (!w_empty[0] && !w_empty[1]) ? r_rr : w_empty[0];

    always_comb begin
        w_pop = 2'b00;
        if (w_load && w_any) w_pop[w_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
            r_out       <= '0;
            r_rr        <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_src <= w_sel;
                r_out     <= w_head[w_sel];
                r_rr      <= ~w_sel;
            end
        end
    end

    assign rec.out_valid = r_out_valid;
    assign rec.out_src   = r_out_src;
    assign rec.out_ovf   = r_out.ovf;
    assign rec.out_type  = r_out.etype;
    assign rec.out_pc    = r_out.pc;
    assign rec.out_data  = r_out.data;
    assign rec.out_ts    = r_out.ts;
endmodule
`default_nettype wire

// File: tb/tb_trace_event_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_event_sched
// Brief    : Directed self-checking bench for trace_event_sched.
// Revision : 1.0
// ============================================================================
module tb_trace_event_sched;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 32;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable, cfg_use_trigger;
    logic [31:0] cfg_start_pc, cfg_stop_pc;
    logic        if_evt_valid, ex_evt_valid;
    logic [1:0]  if_evt_type, ex_evt_type;
    logic [31:0] if_evt_pc, if_evt_data, ex_evt_pc;
    logic        tracing;
    logic [DROP_W-1:0] drop_count;

    trace_event_sched_if #(.TS_W(TS_W)) u_if ();

    trace_event_sched #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_enable(cfg_enable), .cfg_use_trigger(cfg_use_trigger),
        .cfg_start_pc(cfg_start_pc), .cfg_stop_pc(cfg_stop_pc),
        .if_evt_valid(if_evt_valid), .if_evt_type(if_evt_type),
        .if_evt_pc(if_evt_pc), .if_evt_data(if_evt_data),
        .ex_evt_valid(ex_evt_valid), .ex_evt_type(ex_evt_type), .ex_evt_pc(ex_evt_pc),
        .rec(u_if.master), .tracing(tracing), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        src;
        bit        ovf;
        bit [1:0]  etype;
        bit [31:0] pc;
        bit [31:0] data;
        bit [31:0] ts;
    } obs_t;

    obs_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        obs_t o;
        if (rst_n && u_if.out_valid && u_if.out_ready) begin
            o.src = u_if.out_src; o.ovf = u_if.out_ovf; o.etype = u_if.out_type;
            o.pc = u_if.out_pc; o.data = u_if.out_data; o.ts = u_if.out_ts;
            q.push_back(o);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_evt_valid = 0; if_evt_type = 0; if_evt_pc = 0; if_evt_data = 0;
        ex_evt_valid = 0; ex_evt_type = 0; ex_evt_pc = 0;
    endtask

    // Leaves the bench in cycle 0 after reset release (timestamp 0, state IDLE).
    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        q.delete();
    endtask

    task automatic wait_recs(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq("rec_count", 64'(q.size()), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        cfg_enable = 1; cfg_use_trigger = 0;
        cfg_start_pc = 32'h100; cfg_stop_pc = 32'h200;
        u_if.out_ready = 1;
        rst_n = 0;
        tick(); tick();

        // Reset values and first-record latency
        do_reset();
        check_eq("rst_valid", u_if.out_valid, 0);
        check_eq("rst_pc", u_if.out_pc, 0);
        check_eq("rst_ts", u_if.out_ts, 0);
        check_eq("rst_drop", drop_count, 0);
        check_eq("rst_tracing", tracing, 0);
        tick();
        check_eq("tracing_on", tracing, 1);
        if_evt_valid = 1; if_evt_pc = 32'h80; if_evt_data = 32'h13;
        tick();
        idle_inputs();
        check_eq("lat_valid_c1", u_if.out_valid, 0);
        tick();
        check_eq("lat_valid_c2", u_if.out_valid, 1);
        check_eq("lat_src", u_if.out_src, 0);
        check_eq("lat_pc", u_if.out_pc, 32'h80);
        check_eq("lat_data", u_if.out_data, 32'h13);
        check_eq("lat_ts", u_if.out_ts, 1);
        check_eq("lat_ovf", u_if.out_ovf, 0);

        // PC trigger window
        cfg_use_trigger = 1;
        do_reset();
        tick();
        check_eq("armed_tracing", tracing, 0);
        begin
            logic [31:0] pcs [5];
            pcs[0] = 32'h0FC; pcs[1] = 32'h100; pcs[2] = 32'h104; pcs[3] = 32'h200; pcs[4] = 32'h204;
            for (int i = 0; i < 5; i++) begin
                ex_evt_valid = 1; ex_evt_pc = pcs[i];
                tick();
            end
        end
        idle_inputs();
        check_eq("stopped_tracing", tracing, 0);
        wait_recs(3, 10);
        repeat (4) tick();
        check_eq("trig_total", 64'(q.size()), 3);
        if (q.size() == 3) begin
            check_eq("trig_pc0", q[0].pc, 32'h100);
            check_eq("trig_pc1", q[1].pc, 32'h104);
            check_eq("trig_pc2", q[2].pc, 32'h200);
            check_eq("trig_src", q[2].src, 1);
            check_eq("trig_data", q[1].data, 0);
        end

        // Round-robin alternation with both sources active
        cfg_use_trigger = 0;
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) begin
            if_evt_valid = 1; if_evt_pc = 32'h1000 + 32'(4*i); if_evt_data = 32'(i);
            ex_evt_valid = 1; ex_evt_pc = 32'h2000 + 32'(4*i); ex_evt_type = 2'(i % 3);
            tick();
        end
        idle_inputs();
        wait_recs(12, 30);
        if (q.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                check_eq($sformatf("rr_src%0d", k), q[k].src, 64'(k % 2));
                check_eq($sformatf("rr_pc%0d", k), q[k].pc,
                         64'(((k % 2) ? 32'h2000 : 32'h1000) + 32'(4*(k/2))));
            end
            check_eq("rr_ts0", q[0].ts, 1);
            check_eq("rr_type5", q[5].etype, 2);
        end
        check_eq("rr_drop", drop_count, 0);

        // Overflow, drop accounting and in-band markers
        u_if.out_ready = 0;
        do_reset();
        tick();
        for (int i = 1; i <= 7; i++) begin
            if_evt_valid = 1; if_evt_pc = 32'h3000 + 32'(4*i); if_evt_data = 32'(i);
            tick();
        end
        idle_inputs();
        tick(); tick();
        check_eq("ovf_drop2", drop_count, 2);
        check_eq("ovf_hold_data", u_if.out_data, 1);
        u_if.out_ready = 1;
        tick();
        if_evt_valid = 1; if_evt_pc = 32'h3020; if_evt_data = 32'd8;
        tick();
        idle_inputs();
        wait_recs(7, 20);
        repeat (4) tick();
        check_eq("ovf_total", 64'(q.size()), 7);
        if (q.size() == 7) begin
            for (int k = 0; k < 5; k++) begin
                check_eq($sformatf("ovf_ev%0d_data", k), q[k].data, 64'(k + 1));
                check_eq($sformatf("ovf_ev%0d_ovf", k), q[k].ovf, 0);
            end
            check_eq("mark0_ovf", q[5].ovf, 1);
            check_eq("mark0_data", q[5].data, 2);
            check_eq("mark0_pc", q[5].pc, 0);
            check_eq("mark1_ovf", q[6].ovf, 1);
            check_eq("mark1_data", q[6].data, 1);
        end
        check_eq("ovf_drop3", drop_count, 3);

        // Output payload stable under back-pressure
        u_if.out_ready = 0;
        do_reset();
        tick();
        for (int i = 0; i < 8; i++) begin
            ex_evt_valid = 1; ex_evt_pc = 32'h5000 + 32'(4*i);
            tick();
            if (i >= 2) begin
                check_eq($sformatf("hold_valid%0d", i), u_if.out_valid, 1);
                check_eq($sformatf("hold_pc%0d", i), u_if.out_pc, 32'h5000);
                check_eq($sformatf("hold_ts%0d", i), u_if.out_ts, 1);
            end
        end
        idle_inputs();
        check_eq("hold_drop", drop_count, 3);

        // Mid-operation reset discards buffered records
        cfg_use_trigger = 1;
        do_reset();
        check_eq("mid_rst_valid", u_if.out_valid, 0);
        check_eq("mid_rst_drop", drop_count, 0);
        check_eq("mid_rst_tracing", tracing, 0);
        u_if.out_ready = 1;
        tick();
        ex_evt_valid = 1; ex_evt_pc = 32'h0FC;
        tick();
        idle_inputs();
        repeat (5) tick();
        check_eq("mid_rst_empty", 64'(q.size()), 0);
        check_eq("mid_rst_armed", tracing, 0);
        ex_evt_valid = 1; ex_evt_pc = 32'h100;
        tick();
        idle_inputs();
        check_eq("mid_rst_start", tracing, 1);
        wait_recs(1, 10);
        if (q.size() == 1) check_eq("mid_rst_pc", q[0].pc, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
